// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: reset values, fetch FSM states and base opcodes
// used by the fetch unit, decoder and immediate generator.
package rv32_pkg;

  // Canonical NOP (addi x0, x0, 0) loaded into IR after reset or a fetch error
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default architectural PC after reset
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // Fetch stage controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_t;

  // RV32I base opcodes (instruction[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // True when a fetch address is not word aligned
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory request watchdog: counts cycles spent waiting for imem_ack and flags
// the last permitted cycle.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Cycle counter: restart on a new request, advance while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV32I multi-cycle core: issues one instruction memory
// read per controller request, loads IR, advances or redirects the PC and
// reports misaligned-PC and memory-timeout errors.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_go,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        fetch_err
);

  fetch_state_t state_q;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic [31:0]  ir_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_pc_q;
  logic         instr_valid_q;
  logic         fetch_err_q;
  logic         pend_q;
  logic [31:0]  pend_tgt_q;

  logic [31:0]  fetch_addr_d;
  logic         redir_d;
  logic [31:0]  redir_tgt_d;
  logic [31:0]  seq_pc_d;
  logic         tmr_clr_d;
  logic         tmr_en_d;
  logic         tmr_expire_s;

  // Fetch address, effective redirect and watchdog controls
  always_comb begin
    fetch_addr_d = pc_load ? pc_target : pc_q;
    redir_d      = pend_q | pc_load;
    redir_tgt_d  = pc_load ? pc_target : pend_tgt_q;
    seq_pc_d     = imem_addr_q + 32'd4;
    tmr_clr_d    = 1'b0;
    tmr_en_d     = 1'b0;
    if (state_q == ST_REQ) begin
      tmr_en_d = ~imem_ack;
    end else begin
      tmr_clr_d = fetch_go & ~addr_misaligned(fetch_addr_d);
    end
  end

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr_d),
    .en_i     (tmr_en_d),
    .expire_o (tmr_expire_s)
  );

  // Fetch FSM with PC, IR, redirect latch and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      ir_q          <= NOP_INSTR;
      pc_q          <= RESET_PC;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      pend_q        <= 1'b0;
      pend_tgt_q    <= 32'h0000_0000;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (fetch_go) begin
            pc_q <= fetch_addr_d;
            if (addr_misaligned(fetch_addr_d)) begin
              fetch_err_q <= 1'b1;
              ir_q        <= NOP_INSTR;
              state_q     <= ST_ERR;
            end else begin
              fetch_err_q <= 1'b0;
              imem_addr_q <= fetch_addr_d;
              imem_req_q  <= 1'b1;
              state_q     <= ST_REQ;
            end
          end else if (pc_load) begin
            pc_q <= pc_target;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            ir_q          <= imem_rdata;
            instr_pc_q    <= imem_addr_q;
            imem_req_q    <= 1'b0;
            pc_q          <= redir_d ? redir_tgt_d : seq_pc_d;
            pend_q        <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else if (tmr_expire_s) begin
            imem_req_q  <= 1'b0;
            ir_q        <= NOP_INSTR;
            fetch_err_q <= 1'b1;
            if (redir_d) begin
              pc_q <= redir_tgt_d;
            end
            pend_q      <= 1'b0;
            state_q     <= ST_ERR;
          end else if (pc_load) begin
            // Last redirect seen during the request wins
            pend_q     <= 1'b1;
            pend_tgt_q <= pc_target;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          pend_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = ir_q;
  assign pc          = pc_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q == ST_REQ);
  assign fetch_err   = fetch_err_q;

endmodule
